// File: rtl/note_tone_synth.sv
// note_tone_synth: note code -> half-period decoder followed by a 50% duty
// square-wave generator. The note table is built at elaboration from CLK_FREQ.
//
// State     | meaning
// silent    | pwm_interval == 0, output held low, counter parked at 0
// restart   | new interval latched, counter cleared, output level kept
// counting  | counter running toward pwm_interval-1, toggle on reaching it
module note_tone_synth #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int INTERVAL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            note,
  output logic [INTERVAL_W-1:0] pwm_interval,
  output logic                  pwm_out
);

  localparam logic [INTERVAL_W-1:0] ONE = {{(INTERVAL_W-1){1'b0}}, 1'b1};

  // Half-period in clocks for note n, rounded to nearest and saturated.
  // Frequencies are held in centi-Hz so the whole computation stays integer:
  // round(C / (2 * fc/100)) = (200*C + 2*fc) / (4*fc).
  function automatic logic [INTERVAL_W-1:0] half_period(input int n);
    longint fc;
    longint q;
    longint lim;
    case (n)
      1:       fc = 26163;
      2:       fc = 27718;
      3:       fc = 29366;
      4:       fc = 31113;
      5:       fc = 32963;
      6:       fc = 34923;
      7:       fc = 36999;
      8:       fc = 39200;
      9:       fc = 41530;
      10:      fc = 44000;
      11:      fc = 46616;
      12:      fc = 49388;
      13:      fc = 52325;
      14:      fc = 55437;
      15:      fc = 58733;
      default: fc = 0;
    endcase
    lim = (longint'(1) << INTERVAL_W) - 1;
    if (fc == 0) q = 0;
    else         q = (longint'(CLK_FREQ) * 200 + 2 * fc) / (4 * fc);
    if (q > lim) q = lim;
    return q[INTERVAL_W-1:0];
  endfunction

  logic [INTERVAL_W-1:0] note_table [16];

  for (genvar g = 0; g < 16; g++) begin : g_table
    assign note_table[g] = half_period(g);
  end

  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic [INTERVAL_W-1:0] last_q, last_d;
  logic [INTERVAL_W-1:0] cnt_q, cnt_d;
  logic                  out_q, out_d;

  // Decoder: look up the half-period for the note presented this cycle.
  always_comb begin
    interval_d = note_table[note];
  end

  // Generator: silence, phase restart on interval change, or count/toggle.
  // The >= compare lets the counter recover if the interval ever shrinks.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    last_d = interval_q;
    if (interval_q == '0) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (interval_q != last_q) begin
      cnt_d = '0;
    end else if (cnt_q >= interval_q - ONE) begin
      cnt_d = '0;
      out_d = ~out_q;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // State registers for both stages; reset forces immediate silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interval_q <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      out_q      <= 1'b0;
    end else begin
      interval_q <= interval_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
    end
  end

  assign pwm_interval = interval_q;
  assign pwm_out      = out_q;

endmodule

// File: tb/tb_note_tone_synth.sv
// Bench for note_tone_synth: a 12 MHz instance and an 880 Hz instance, each
// tracked by a closed-form waveform model computed from the note frequencies.
module tb_note_tone_synth;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  note = 4'd0;
  logic [3:0]  note_s = 4'd0;
  logic [15:0] iv, iv_s;
  logic        po, po_s;

  int checks = 0;
  int errors = 0;

  note_tone_synth #(.CLK_FREQ(12_000_000), .INTERVAL_W(16)) dut (
    .clk(clk), .rst(rst), .note(note), .pwm_interval(iv), .pwm_out(po));

  note_tone_synth #(.CLK_FREQ(880), .INTERVAL_W(16)) dut_s (
    .clk(clk), .rst(rst), .note(note_s), .pwm_interval(iv_s), .pwm_out(po_s));

  always #5 clk = ~clk;

  // Reference: note frequency in Hz.
  function automatic real note_freq(int n);
    case (n)
      1: return 261.63;  2: return 277.18;  3: return 293.66;  4: return 311.13;
      5: return 329.63;  6: return 349.23;  7: return 369.99;  8: return 392.00;
      9: return 415.30;  10: return 440.00; 11: return 466.16; 12: return 493.88;
      13: return 523.25; 14: return 554.37; 15: return 587.33;
      default: return 0.0;
    endcase
  endfunction

  function automatic int ref_interval(real fclk, int n);
    int r;
    if (n == 0) return 0;
    r = $rtoi(fclk / (2.0 * note_freq(n)) + 0.5);
    if (r > 65535) r = 65535;
    return r;
  endfunction

  // Waveform model: level = base level at the last restart, flipped once per
  // elapsed interval since that restart; interval 0 forces low.
  typedef struct {
    int edge_n;
    int intv;
    int prev;
    int restart;
    bit base;
    bit out;
  } mdl_t;

  function automatic mdl_t model_step(mdl_t m, int nxt);
    mdl_t r;
    int   cur;
    r = m;
    r.edge_n = m.edge_n + 1;
    cur = m.intv;
    if (cur == 0) begin
      r.out = 1'b0;
    end else if (cur != m.prev) begin
      r.restart = r.edge_n;
      r.base    = m.out;
      r.out     = m.out;
    end else begin
      r.out = m.base ^ ((((r.edge_n - m.restart) / cur) % 2) != 0);
    end
    r.prev = cur;
    r.intv = nxt;
    return r;
  endfunction

  mdl_t mb = '{default: 0};
  mdl_t ms = '{default: 0};

  always @(posedge clk or posedge rst) begin
    if (rst) mb = '{default: 0};
    else     mb = model_step(mb, ref_interval(12.0e6, int'(note)));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) ms = '{default: 0};
    else     ms = model_step(ms, ref_interval(880.0, int'(note_s)));
  end

  task automatic test_reset();
    int e;
    int rise_e;
    int fall_e;
    int rise2_e;
    note = 4'd10;
    note_s = 4'd10;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (iv !== 16'd0) begin errors++; $display("FAIL reset_interval got %0d want 0", iv); end
    checks++; if (po !== 1'b0) begin errors++; $display("FAIL reset_out got %0b want 0", po); end
    checks++; if (iv_s !== 16'd0) begin errors++; $display("FAIL reset_interval_s got %0d want 0", iv_s); end
    checks++; if (po_s !== 1'b0) begin errors++; $display("FAIL reset_out_s got %0b want 0", po_s); end
    rst = 1'b0;
    e = 0; rise_e = -1;
    while (e < 20000 && rise_e < 0) begin
      @(posedge clk); #1; e++;
      if (e == 1) begin
        checks++; if (iv !== 16'd13636) begin errors++; $display("FAIL reset_first_interval got %0d want 13636", iv); end
      end
      checks++;
      if (po !== mb.out || iv !== 16'(mb.intv)) begin
        errors++; $display("FAIL reset_model edge %0d got %0d/%0b want %0d/%0b", e, iv, po, mb.intv, mb.out);
      end
      if (po === 1'b1) rise_e = e;
    end
    checks++; if (rise_e != 13638) begin errors++; $display("FAIL reset_first_rise got edge %0d want 13638", rise_e); end
    e = 0; fall_e = -1;
    while (e < 20000 && fall_e < 0) begin
      @(posedge clk); #1; e++;
      checks++;
      if (po !== mb.out) begin errors++; $display("FAIL high_phase_model got %0b want %0b", po, mb.out); end
      if (po === 1'b0) fall_e = e;
    end
    checks++; if (fall_e != 13636) begin errors++; $display("FAIL high_time got %0d want 13636", fall_e); end
    e = 0; rise2_e = -1;
    while (e < 20000 && rise2_e < 0) begin
      @(posedge clk); #1; e++;
      checks++;
      if (po !== mb.out) begin errors++; $display("FAIL low_phase_model got %0b want %0b", po, mb.out); end
      if (po === 1'b1) rise2_e = e;
    end
    checks++; if (rise2_e != 13636) begin errors++; $display("FAIL low_time got %0d want 13636", rise2_e); end
  endtask

  task automatic test_note_change();
    int  e;
    int  t1;
    int  t2;
    logic lvl;
    repeat (100) begin
      @(posedge clk); #1;
      checks++; if (po !== 1'b1) begin errors++; $display("FAIL change_pre_high got %0b want 1", po); end
    end
    @(negedge clk);
    lvl = po;
    note = 4'd13;
    e = 0; t1 = -1;
    while (e < 13000 && t1 < 0) begin
      @(posedge clk); #1; e++;
      if (e == 1) begin
        checks++; if (iv !== 16'd11467) begin errors++; $display("FAIL change_interval got %0d want 11467", iv); end
      end
      checks++;
      if (po !== mb.out) begin errors++; $display("FAIL change_model edge %0d got %0b want %0b", e, po, mb.out); end
      if (po !== lvl) t1 = e;
    end
    checks++; if (t1 != 11469) begin errors++; $display("FAIL change_first_toggle got edge %0d want 11469", t1); end
    lvl = po;
    e = 0; t2 = -1;
    while (e < 13000 && t2 < 0) begin
      @(posedge clk); #1; e++;
      if (po !== lvl) t2 = e;
    end
    checks++; if (t2 != 11467) begin errors++; $display("FAIL change_half_period got %0d want 11467", t2); end
    checks++; if (t1 - 2 + t2 != 22934) begin errors++; $display("FAIL change_period got %0d want 22934", t1 - 2 + t2); end
  endtask

  task automatic test_tone_to_rest();
    @(negedge clk);
    note = 4'd1;
    repeat (50) begin
      @(posedge clk); #1;
      checks++; if (po !== 1'b1) begin errors++; $display("FAIL rest_restart_hold got %0b want 1", po); end
    end
    @(negedge clk);
    note = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (po !== 1'b0) begin errors++; $display("FAIL rest_low got %0b want 0", po); end
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (po !== 1'b0 || iv !== 16'd0) begin errors++; $display("FAIL rest_stay got %0d/%0b want 0/0", iv, po); end
    end
  endtask

  task automatic test_table_sweep();
    int exp_c;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      note = 4'(n);
      case (n)
        0: exp_c = 0;      1: exp_c = 22933;  5: exp_c = 18202;  8: exp_c = 15306;
        10: exp_c = 13636; 13: exp_c = 11467; 15: exp_c = 10216;
        default: exp_c = -1;
      endcase
      repeat (3) begin
        @(posedge clk); #1;
        checks++;
        if (iv !== 16'(ref_interval(12.0e6, n))) begin
          errors++; $display("FAIL sweep_table note %0d got %0d want %0d", n, iv, ref_interval(12.0e6, n));
        end
      end
      if (exp_c >= 0) begin
        checks++; if (iv !== 16'(exp_c)) begin errors++; $display("FAIL sweep_default note %0d got %0d want %0d", n, iv, exp_c); end
      end
    end
  endtask

  task automatic test_async_reset();
    int k;
    @(negedge clk);
    note = 4'd10;
    note_s = 4'd10;
    repeat (4) @(posedge clk);
    #1;
    k = 0;
    while (po_s !== 1'b1 && k < 6) begin @(posedge clk); #1; k++; end
    checks++; if (po_s !== 1'b1) begin errors++; $display("FAIL async_pre_high got %0b want 1", po_s); end
    #2 rst = 1'b1;
    #1;
    checks++; if (iv !== 16'd0 || po !== 1'b0) begin errors++; $display("FAIL async_big got %0d/%0b want 0/0", iv, po); end
    checks++; if (iv_s !== 16'd0 || po_s !== 1'b0) begin errors++; $display("FAIL async_small got %0d/%0b want 0/0", iv_s, po_s); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (iv !== 16'd0) begin errors++; $display("FAIL async_release got %0d want 0", iv); end
    @(posedge clk); #1;
    checks++; if (iv !== 16'd13636 || po !== 1'b0) begin errors++; $display("FAIL async_resample got %0d/%0b want 13636/0", iv, po); end
    checks++; if (iv_s !== 16'd1) begin errors++; $display("FAIL async_resample_s got %0d want 1", iv_s); end
  endtask

  task automatic test_small_clock();
    logic prev;
    @(negedge clk);
    note_s = 4'd10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (iv_s !== 16'd1) begin errors++; $display("FAIL small_note10 got %0d want 1", iv_s); end
    prev = po_s;
    repeat (10) begin
      @(posedge clk); #1;
      checks++; if (po_s === prev) begin errors++; $display("FAIL small_toggle got %0b want %0b", po_s, ~prev); end
      prev = po_s;
    end
    @(negedge clk);
    note_s = 4'd1;
    @(posedge clk); #1;
    checks++; if (iv_s !== 16'd2) begin errors++; $display("FAIL small_note1 got %0d want 2", iv_s); end
  endtask

  task automatic test_random();
    int hold;
    repeat (300) begin
      @(negedge clk);
      note   = 4'($urandom_range(0, 15));
      note_s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        #1;
        checks++; if (po !== 1'b0 || po_s !== 1'b0) begin errors++; $display("FAIL rand_reset got %0b/%0b want 0/0", po, po_s); end
        #1 rst = 1'b0;
      end
      hold = $urandom_range(1, 8);
      repeat (hold) begin
        @(posedge clk); #1;
        checks++;
        if (iv !== 16'(mb.intv) || po !== mb.out) begin
          errors++; $display("FAIL rand_big got %0d/%0b want %0d/%0b", iv, po, mb.intv, mb.out);
        end
        checks++;
        if (iv_s !== 16'(ms.intv) || po_s !== ms.out) begin
          errors++; $display("FAIL rand_small got %0d/%0b want %0d/%0b", iv_s, po_s, ms.intv, ms.out);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_note_change();
    test_tone_to_rest();
    test_table_sweep();
    test_async_reset();
    test_small_clock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
